// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master port (AR + R) among NUM_REQ requesters.
// One burst in flight at a time; the beat count of each burst is checked against its ARLEN.
module axi_rd_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned AWID_WIDTH   = 4,
  parameter int unsigned AWADDR_WIDTH = 32,
  parameter int unsigned WDATA_WIDTH  = 64
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_REQ*AWID_WIDTH-1:0]     S_ARID,
  input  logic [NUM_REQ*AWADDR_WIDTH-1:0]   S_ARADDR,
  input  logic [NUM_REQ*8-1:0]              S_ARLEN,
  input  logic [NUM_REQ*3-1:0]              S_ARSIZE,
  input  logic [NUM_REQ*2-1:0]              S_ARBURST,
  input  logic [NUM_REQ*4-1:0]              S_ARREGION,
  input  logic [NUM_REQ-1:0]                S_ARVALID,
  output logic [NUM_REQ-1:0]                S_ARREADY,
  output logic [NUM_REQ*AWID_WIDTH-1:0]     S_RID,
  output logic [NUM_REQ*WDATA_WIDTH-1:0]    S_RDATA,
  output logic [NUM_REQ*2-1:0]              S_RRESP,
  output logic [NUM_REQ-1:0]                S_RLAST,
  output logic [NUM_REQ-1:0]                S_RVALID,
  input  logic [NUM_REQ-1:0]                S_RREADY,
  output logic [AWID_WIDTH-1:0]             M_ARID,
  output logic [AWADDR_WIDTH-1:0]           M_ARADDR,
  output logic [7:0]                        M_ARLEN,
  output logic [2:0]                        M_ARSIZE,
  output logic [1:0]                        M_ARBURST,
  output logic [3:0]                        M_ARREGION,
  output logic                              M_ARVALID,
  input  logic                              M_ARREADY,
  input  logic [AWID_WIDTH-1:0]             M_RID,
  input  logic [WDATA_WIDTH-1:0]            M_RDATA,
  input  logic [1:0]                        M_RRESP,
  input  logic                              M_RLAST,
  input  logic                              M_RVALID,
  output logic                              M_RREADY,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              len_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;
  logic [IdxW-1:0]    gnt_idx, pick_idx;
  logic               pick_valid;
  logic               ar_hs, r_hs;

  assign gnt     = gnt_q;
  assign len_err = len_err_q;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gnt_idx = IdxW'(i);
    end
  end

  // Scan starts just past the last owner, so the requester just served ranks lowest.
  always_comb begin : p_arb
    int unsigned cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_valid && S_ARVALID[cand[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    M_ARID     = '0;
    M_ARADDR   = '0;
    M_ARLEN    = '0;
    M_ARSIZE   = '0;
    M_ARBURST  = '0;
    M_ARREGION = '0;
    M_ARVALID  = 1'b0;
    M_RREADY   = 1'b0;
    S_ARREADY  = '0;
    S_RID      = '0;
    S_RDATA    = '0;
    S_RRESP    = '0;
    S_RLAST    = '0;
    S_RVALID   = '0;
    ar_hs      = 1'b0;
    r_hs       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          state_d         = StAddr;
        end
      end
      StAddr: begin
        M_ARID             = S_ARID[gnt_idx*AWID_WIDTH +: AWID_WIDTH];
        M_ARADDR           = S_ARADDR[gnt_idx*AWADDR_WIDTH +: AWADDR_WIDTH];
        M_ARLEN            = S_ARLEN[gnt_idx*8 +: 8];
        M_ARSIZE           = S_ARSIZE[gnt_idx*3 +: 3];
        M_ARBURST          = S_ARBURST[gnt_idx*2 +: 2];
        M_ARREGION         = S_ARREGION[gnt_idx*4 +: 4];
        M_ARVALID          = S_ARVALID[gnt_idx];
        S_ARREADY[gnt_idx] = M_ARREADY;
        ar_hs              = M_ARVALID && M_ARREADY;
        if (ar_hs) begin
          beat_cnt_d = S_ARLEN[gnt_idx*8 +: 8];
          state_d    = StData;
        end
      end
      StData: begin
        S_RVALID[gnt_idx]                              = M_RVALID;
        S_RID[gnt_idx*AWID_WIDTH +: AWID_WIDTH]        = M_RID;
        S_RDATA[gnt_idx*WDATA_WIDTH +: WDATA_WIDTH]    = M_RDATA;
        S_RRESP[gnt_idx*2 +: 2]                        = M_RRESP;
        S_RLAST[gnt_idx]                               = M_RLAST;
        M_RREADY                                       = S_RREADY[gnt_idx];
        r_hs                                           = M_RVALID && M_RREADY;
        if (r_hs) begin
          if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
          // Early RLAST or a beat past ARLEN; the grant still follows RLAST only.
          if (M_RLAST ? (beat_cnt_q != 8'd0) : (beat_cnt_q == 8'd0)) len_err_d = 1'b1;
          if (M_RLAST) begin
            rr_ptr_d = gnt_idx;
            gnt_d    = '0;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rr_ptr_q   <= IdxW'(NUM_REQ - 1);
      beat_cnt_q <= 8'd0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a scripted slave drives R beats into a scoreboard that is
// drained as requesters accept them; a second 3-requester instance checks grant rotation.
module tb_axi_rd_arbiter;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [7:0]   S_ARID;
  logic [63:0]  S_ARADDR;
  logic [15:0]  S_ARLEN;
  logic [5:0]   S_ARSIZE;
  logic [3:0]   S_ARBURST;
  logic [7:0]   S_ARREGION;
  logic [1:0]   S_ARVALID, S_ARREADY;
  logic [7:0]   S_RID;
  logic [127:0] S_RDATA;
  logic [3:0]   S_RRESP;
  logic [1:0]   S_RLAST, S_RVALID, S_RREADY;
  logic [3:0]   M_ARID;
  logic [31:0]  M_ARADDR;
  logic [7:0]   M_ARLEN;
  logic [2:0]   M_ARSIZE;
  logic [1:0]   M_ARBURST;
  logic [3:0]   M_ARREGION;
  logic         M_ARVALID, M_ARREADY;
  logic [3:0]   M_RID;
  logic [63:0]  M_RDATA;
  logic [1:0]   M_RRESP;
  logic         M_RLAST, M_RVALID, M_RREADY;
  logic [1:0]   gnt;
  logic         len_err;

  logic         rst3_n;
  logic [11:0]  t3_S_ARID;
  logic [95:0]  t3_S_ARADDR;
  logic [23:0]  t3_S_ARLEN;
  logic [8:0]   t3_S_ARSIZE;
  logic [5:0]   t3_S_ARBURST;
  logic [11:0]  t3_S_ARREGION;
  logic [2:0]   t3_S_ARVALID, t3_S_ARREADY;
  logic [11:0]  t3_S_RID;
  logic [191:0] t3_S_RDATA;
  logic [5:0]   t3_S_RRESP;
  logic [2:0]   t3_S_RLAST, t3_S_RVALID, t3_S_RREADY;
  logic [3:0]   t3_M_ARID;
  logic [31:0]  t3_M_ARADDR;
  logic [7:0]   t3_M_ARLEN;
  logic [2:0]   t3_M_ARSIZE;
  logic [1:0]   t3_M_ARBURST;
  logic [3:0]   t3_M_ARREGION;
  logic         t3_M_ARVALID, t3_M_ARREADY;
  logic [3:0]   t3_M_RID;
  logic [63:0]  t3_M_RDATA;
  logic [1:0]   t3_M_RRESP;
  logic         t3_M_RLAST, t3_M_RVALID, t3_M_RREADY;
  logic [2:0]   t3_gnt;
  logic         t3_len_err;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARREGION(S_ARREGION), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARREGION(M_ARREGION), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .gnt(gnt), .len_err(len_err)
  );

  axi_rd_arbiter #(.NUM_REQ(3)) u_dut3 (
    .ACLK(ACLK), .ARESETn(rst3_n),
    .S_ARID(t3_S_ARID), .S_ARADDR(t3_S_ARADDR), .S_ARLEN(t3_S_ARLEN),
    .S_ARSIZE(t3_S_ARSIZE), .S_ARBURST(t3_S_ARBURST), .S_ARREGION(t3_S_ARREGION),
    .S_ARVALID(t3_S_ARVALID), .S_ARREADY(t3_S_ARREADY), .S_RID(t3_S_RID),
    .S_RDATA(t3_S_RDATA), .S_RRESP(t3_S_RRESP), .S_RLAST(t3_S_RLAST),
    .S_RVALID(t3_S_RVALID), .S_RREADY(t3_S_RREADY),
    .M_ARID(t3_M_ARID), .M_ARADDR(t3_M_ARADDR), .M_ARLEN(t3_M_ARLEN),
    .M_ARSIZE(t3_M_ARSIZE), .M_ARBURST(t3_M_ARBURST), .M_ARREGION(t3_M_ARREGION),
    .M_ARVALID(t3_M_ARVALID), .M_ARREADY(t3_M_ARREADY), .M_RID(t3_M_RID),
    .M_RDATA(t3_M_RDATA), .M_RRESP(t3_M_RRESP), .M_RLAST(t3_M_RLAST),
    .M_RVALID(t3_M_RVALID), .M_RREADY(t3_M_RREADY),
    .gnt(t3_gnt), .len_err(t3_len_err)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_id   [2];
  logic [31:0] exp_addr [2];
  logic [7:0]  exp_len  [2];
  bit          tog;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise_req(input int r, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len);
    exp_id[r]                = id;
    exp_addr[r]              = addr;
    exp_len[r]               = len;
    S_ARID[r*4 +: 4]         = id;
    S_ARADDR[r*32 +: 32]     = addr;
    S_ARLEN[r*8 +: 8]        = len;
    S_ARSIZE[r*3 +: 3]       = 3'd3;
    S_ARBURST[r*2 +: 2]      = 2'b01;
    S_ARREGION[r*4 +: 4]     = 4'(r + 5);
    S_ARVALID[r]             = 1'b1;
  endtask

  task automatic pop_compare(input int r);
    beat_t e;
    check("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("s_rdata", S_RDATA[r*64 +: 64], e.data);
    check("s_rid",   S_RID[r*4 +: 4], e.id);
    check("s_rresp", S_RRESP[r*2 +: 2], e.resp);
    check("s_rlast", S_RLAST[r], e.last);
  endtask

  // Waits for the AR phase of requester r, then plays `beats` R beats (RLAST on the final one).
  task automatic serve(input int r, input int exp_wait, input int beats, input bit toggle,
                       input int abort_at);
    int waits = 0;
    bit seen = 0;
    bit acc;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ACLK);
      M_RVALID  = 1'b0;
      M_RLAST   = 1'b0;
      M_ARREADY = 1'b1;
      #1;
      if (M_ARVALID) seen = 1'b1;
      else waits++;
    end
    check("ar_seen", seen, 1);
    if (!seen) return;
    if (exp_wait >= 0) check("ar_latency", waits, exp_wait);
    check("gnt_addr", gnt, 2'b01 << r);
    check("m_araddr", M_ARADDR, exp_addr[r]);
    check("m_arid", M_ARID, exp_id[r]);
    check("m_arlen", M_ARLEN, exp_len[r]);
    check("s_arready", S_ARREADY, 2'b01 << r);
    @(negedge ACLK);
    S_ARVALID[r]   = 1'b0;
    M_ARREADY      = 1'b0;
    S_RREADY       = '0;
    S_RREADY[1-r]  = 1'b1;
    tog            = 1'b0;
    for (int b = 0; b < beats; b++) begin
      M_RVALID = 1'b1;
      M_RDATA  = {$urandom, $urandom};
      M_RID    = exp_id[r];
      M_RRESP  = 2'(b);
      M_RLAST  = (b == beats - 1);
      if (b == abort_at) begin
        ARESETn = 1'b0;
        #1;
        check("abort_gnt", gnt, 0);
        check("abort_rvalid", S_RVALID, 0);
        check("abort_rready", M_RREADY, 0);
        check("abort_arvalid", M_ARVALID, 0);
        check("abort_arready", S_ARREADY, 0);
        return;
      end
      sb.push_back('{id: M_RID, data: M_RDATA, resp: M_RRESP, last: M_RLAST});
      acc = 1'b0;
      for (int c = 0; c < 10 && !acc; c++) begin
        if (c > 0) @(negedge ACLK);
        if (toggle) begin
          tog          = ~tog;
          S_RREADY[r]  = tog;
        end else begin
          S_RREADY[r]  = 1'b1;
        end
        #1;
        check("m_rready", M_RREADY, S_RREADY[r]);
        check("other_rvalid", S_RVALID[1-r], 0);
        if (S_RVALID[r] && S_RREADY[r]) begin
          acc = 1'b1;
          pop_compare(r);
        end
      end
      check("beat_accepted", acc, 1);
      if (b < beats - 1) @(negedge ACLK);
    end
  endtask

  task automatic finish_idle(input logic exp_err);
    @(negedge ACLK);
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    S_RREADY = '0;
    #1;
    check("idle_gnt", gnt, 0);
    check("idle_arvalid", M_ARVALID, 0);
    check("len_err", len_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] got [6];
    logic [2:0] prev;
    int         n_g;

    ARESETn = 1'b0;
    S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0;
    S_ARREGION = '0; S_ARVALID = '0; S_RREADY = '0;
    M_ARREADY = 1'b0; M_RID = '0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;
    rst3_n = 1'b0;
    t3_S_ARID = '0; t3_S_ARADDR = '0; t3_S_ARLEN = '0; t3_S_ARSIZE = '0; t3_S_ARBURST = '0;
    t3_S_ARREGION = '0; t3_S_ARVALID = '0; t3_S_RREADY = '0; t3_M_ARREADY = 1'b0;
    t3_M_RID = '0; t3_M_RDATA = '0; t3_M_RRESP = '0; t3_M_RLAST = 1'b0; t3_M_RVALID = 1'b0;

    // Reset with activity on every input: all handshakes must stay low.
    S_ARVALID = 2'b11; M_RVALID = 1'b1; S_RREADY = 2'b11; M_ARREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_len_err", len_err, 0);
    check("rst_arvalid", M_ARVALID, 0);
    check("rst_rready", M_RREADY, 0);
    check("rst_arready", S_ARREADY, 0);
    check("rst_rvalid", S_RVALID, 0);
    S_ARVALID = '0; M_RVALID = 1'b0; S_RREADY = '0;
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Single req0 burst of 4 beats.
    raise_req(0, 4'h3, 32'h1000_0040, 8'd3);
    #1;
    check("ar_idle_first", M_ARVALID, 0);
    serve(0, 0, 4, 1'b0, -1);
    finish_idle(1'b0);

    // Both requesters valid out of reset; req0 re-requests behind req1.
    @(negedge ACLK);
    ARESETn = 1'b0;
    raise_req(0, 4'h1, 32'h2000_0000, 8'd1);
    raise_req(1, 4'h9, 32'h3000_0100, 8'd2);
    @(negedge ACLK);
    ARESETn = 1'b1;
    serve(0, 0, 2, 1'b0, -1);
    raise_req(0, 4'h2, 32'h2000_0800, 8'd0);
    serve(1, 1, 3, 1'b0, -1);
    serve(0, 1, 1, 1'b0, -1);
    finish_idle(1'b0);

    // Backpressure on an 8-beat req1 burst.
    raise_req(1, 4'hA, 32'h4000_0000, 8'd7);
    serve(1, 0, 8, 1'b1, -1);
    finish_idle(1'b0);

    // Early RLAST sets the sticky error; a clean burst afterwards keeps it.
    raise_req(0, 4'h4, 32'h5000_0000, 8'd3);
    serve(0, 0, 3, 1'b0, -1);
    finish_idle(1'b1);
    raise_req(1, 4'h5, 32'h5000_1000, 8'd1);
    serve(1, 0, 2, 1'b0, -1);
    finish_idle(1'b1);

    // Reset during DATA beat 1, then req1 alone.
    raise_req(0, 4'h6, 32'h6000_0000, 8'd3);
    serve(0, 0, 4, 1'b0, 1);
    @(negedge ACLK);
    #1;
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_rvalid", S_RVALID, 0);
    check("rst_mid_len_err", len_err, 0);
    @(negedge ACLK);
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    ARESETn  = 1'b1;
    raise_req(1, 4'h7, 32'h7000_0000, 8'd2);
    serve(1, 0, 3, 1'b0, -1);
    finish_idle(1'b0);
    check("sb_drained", sb.size(), 0);

    // Three requesters, always valid, single-beat bursts.
    t3_S_ARVALID = 3'b111; t3_M_ARREADY = 1'b1; t3_M_RVALID = 1'b1; t3_M_RLAST = 1'b1;
    t3_S_RREADY = 3'b111;
    for (int i = 0; i < 6; i++) got[i] = '0;
    prev = '0;
    n_g  = 0;
    @(negedge ACLK);
    rst3_n = 1'b1;
    for (int c = 0; c < 60 && n_g < 6; c++) begin
      @(negedge ACLK);
      #1;
      if (t3_gnt != 3'b000 && prev == 3'b000) begin
        got[n_g] = t3_gnt;
        n_g++;
      end
      prev = t3_gnt;
    end
    check("n3_grants", n_g, 6);
    for (int i = 0; i < 6; i++) check("n3_order", got[i], 3'b001 << (i % 3));
    check("n3_len_err", t3_len_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
